// File: rtl/tx_bus_control.sv
// rtl/tx_bus_control.sv - builds and sends the response frame for each accepted bus request
// Optional tx_done watchdog enabled by defining TX_TIMEOUT_EN.
module tx_bus_control #(
  parameter logic [7:0]  MASTER_DA   = 8'h00,
  parameter logic [7:0]  ACK_FC      = 8'h60,
  parameter int          PAYLOAD_LEN = 128,
  parameter logic [19:0] TIMEOUT_CYC = 20'd100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ini_done,
  input  logic [2:0]  rack_id,
  input  logic [3:0]  slot_id,
  input  logic        rx_flag,
  input  logic [8:0]  rx_mode,
  input  logic [23:0] rx_addr,
  output logic        lcdub_rden,
  output logic [23:0] lcdub_raddr,
  input  logic [7:0]  lcdub_rdata,
  output logic        tx_buf_wren,
  output logic [10:0] tx_buf_waddr,
  output logic [7:0]  tx_buf_wdata,
  output logic [10:0] tx_len,
  output logic        tx_start,
  input  logic        tx_done,
  output logic        tx_busy,
  output logic        req_drop,
  output logic        tx_timeout_err
);

  typedef enum logic [2:0] {IDLE, WAIT_REQ, HDR, PAYLOAD, STATUS, START, WAIT_DONE} state_t;

  localparam logic [10:0] PLEN      = 11'(PAYLOAD_LEN);
  localparam logic [10:0] FRAME_LEN = 11'(PAYLOAD_LEN + 7);

  state_t      state;
  logic [1:0]  ini_sr, rx_sr;
  logic        ini_rise, rx_rise, in_frame;
  logic [7:0]  sa_q, mode_q, wdata_q, sa_calc;
  logic [23:0] addr_q;
  logic [10:0] cnt;
  logic        pl_wr;
`ifdef TX_TIMEOUT_EN
  logic [19:0] wd_cnt;
`else
  logic        unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign tx_timeout_err = 1'b0;
`endif
  logic        unused_mode;
  assign unused_mode = rx_mode[8];

  assign ini_rise = ini_sr[0] & ~ini_sr[1];
  assign rx_rise  = rx_sr[0] & ~rx_sr[1];
  assign in_frame = (state != IDLE) && (state != WAIT_REQ);
  assign sa_calc  = {5'b0, rack_id} * 8'd14 + 8'd14 - {4'b0, slot_id};

  // Payload bytes come straight from the RAM read port so writes trail reads by one cycle.
  assign tx_buf_wdata = pl_wr ? lcdub_rdata : wdata_q;

  function automatic logic [7:0] hdr_byte(input logic [2:0] idx);
    case (idx)
      3'd1:    hdr_byte = sa_q;
      3'd2:    hdr_byte = ACK_FC;
      3'd3:    hdr_byte = mode_q;
      3'd4:    hdr_byte = addr_q[23:16];
      3'd5:    hdr_byte = addr_q[15:8];
      3'd6:    hdr_byte = addr_q[7:0];
      default: hdr_byte = MASTER_DA;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      ini_sr       <= 2'b00;
      rx_sr        <= 2'b00;
      sa_q         <= 8'h00;
      mode_q       <= 8'h00;
      addr_q       <= 24'h0;
      cnt          <= 11'd0;
      wdata_q      <= 8'h00;
      pl_wr        <= 1'b0;
      lcdub_rden   <= 1'b0;
      lcdub_raddr  <= 24'h0;
      tx_buf_wren  <= 1'b0;
      tx_buf_waddr <= 11'd0;
      tx_len       <= 11'd0;
      tx_start     <= 1'b0;
      tx_busy      <= 1'b0;
      req_drop     <= 1'b0;
`ifdef TX_TIMEOUT_EN
      wd_cnt         <= 20'd0;
      tx_timeout_err <= 1'b0;
`endif
    end else begin
      ini_sr      <= {ini_sr[0], ini_done};
      rx_sr       <= {rx_sr[0], rx_flag};
      tx_buf_wren <= 1'b0;
      lcdub_rden  <= 1'b0;
      pl_wr       <= 1'b0;
      tx_start    <= 1'b0;
      req_drop    <= rx_rise && in_frame;
`ifdef TX_TIMEOUT_EN
      tx_timeout_err <= 1'b0;
`endif
      case (state)
        IDLE: if (ini_rise) begin
          sa_q  <= sa_calc;
          state <= WAIT_REQ;
        end
        WAIT_REQ: if (rx_rise) begin
          mode_q <= rx_mode[7:0];
          addr_q <= rx_addr;
          if (rx_mode[7:0] <= 8'd2) begin
            state        <= HDR;
            tx_busy      <= 1'b1;
            tx_buf_wren  <= 1'b1;
            tx_buf_waddr <= 11'd0;
            wdata_q      <= MASTER_DA;
            cnt          <= 11'd0;
          end
        end
        // cnt is the header byte currently presented on the write port
        HDR: if (cnt != 11'd6) begin
          cnt          <= cnt + 11'd1;
          tx_buf_wren  <= 1'b1;
          tx_buf_waddr <= cnt + 11'd1;
          wdata_q      <= hdr_byte(cnt[2:0] + 3'd1);
        end else if (mode_q < 8'd2) begin
          state       <= PAYLOAD;
          cnt         <= 11'd0;
          lcdub_rden  <= 1'b1;
          lcdub_raddr <= addr_q;
          tx_len      <= FRAME_LEN;
        end else begin
          state        <= STATUS;
          tx_buf_wren  <= 1'b1;
          tx_buf_waddr <= 11'd7;
          wdata_q      <= 8'h00;
          tx_len       <= 11'd8;
        end
        // cnt is the read index presented this cycle; its data is written next cycle
        PAYLOAD: if (cnt == PLEN) begin
          state    <= START;
          tx_start <= 1'b1;
        end else begin
          tx_buf_wren  <= 1'b1;
          pl_wr        <= 1'b1;
          tx_buf_waddr <= 11'd7 + cnt;
          cnt          <= cnt + 11'd1;
          if (cnt + 11'd1 != PLEN) begin
            lcdub_rden  <= 1'b1;
            lcdub_raddr <= addr_q + {13'b0, cnt} + 24'd1;
          end
        end
        STATUS: begin
          state    <= START;
          tx_start <= 1'b1;
        end
        START: begin
          state <= WAIT_DONE;
`ifdef TX_TIMEOUT_EN
          wd_cnt <= 20'd0;
`endif
        end
        WAIT_DONE: if (tx_done) begin
          tx_busy <= 1'b0;
          state   <= WAIT_REQ;
`ifdef TX_TIMEOUT_EN
        end else if (wd_cnt == TIMEOUT_CYC - 20'd1) begin
          tx_timeout_err <= 1'b1;
          tx_busy        <= 1'b0;
          state          <= WAIT_REQ;
        end else begin
          wd_cnt <= wd_cnt + 20'd1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
